// File: rtl/updown_counter_param_if.sv
// Control and status bundle for updown_counter_param.
// master drives count controls; slave (the counter) returns count and flags.
interface updown_counter_param_if #(
    parameter int WIDTH = 4
);
    logic             en;
    logic             up;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic [WIDTH-1:0] out;
    logic             tc;
    logic             ovf;
    logic             at_max;
    logic             at_min;

    modport master (
        output en, up, load, load_val,
        input  out, tc, ovf, at_max, at_min
    );

    modport slave (
        input  en, up, load, load_val,
        output out, tc, ovf, at_max, at_min
    );
endinterface

// File: rtl/updown_counter_param.sv
// Parametrised up/down counter over 0..MAX_COUNT with load, wrap/saturate, tc pulse and sticky ovf.
// Latency: out/tc/ovf one clock after sampling, at_max/at_min combinational; no backpressure.
module updown_counter_param #(
    parameter int WIDTH     = 4,
    parameter int MAX_COUNT = (1 << WIDTH) - 1,
    parameter bit SATURATE  = 1'b0
) (
    input  logic                   clk_i,
    input  logic                   reset_i,
    updown_counter_param_if.slave  bus
);
    localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX_COUNT);

    logic [WIDTH-1:0] out_q, out_d;
    logic             tc_q,  tc_d;
    logic             ovf_q, ovf_d;

    // Priority is load over en; reset is handled in the register process.
    always_comb begin
        out_d = out_q;
        tc_d  = 1'b0;
        ovf_d = ovf_q;
        if (bus.load) begin
            out_d = (bus.load_val > MAX_V) ? MAX_V : bus.load_val;
            ovf_d = 1'b0;
        end else if (bus.en) begin
            if (bus.up) begin
                if (out_q < MAX_V) begin
                    out_d = out_q + WIDTH'(1);
                end else begin
                    out_d = SATURATE ? out_q : '0;
                    tc_d  = 1'b1;
                    ovf_d = 1'b1;
                end
            end else begin
                if (out_q != '0) begin
                    out_d = out_q - WIDTH'(1);
                end else begin
                    out_d = SATURATE ? out_q : MAX_V;
                    tc_d  = 1'b1;
                    ovf_d = 1'b1;
                end
            end
        end
    end

    // Reset value tracks the direction sampled in the reset cycle.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            out_q <= bus.up ? '0 : MAX_V;
            tc_q  <= 1'b0;
            ovf_q <= 1'b0;
        end else begin
            out_q <= out_d;
            tc_q  <= tc_d;
            ovf_q <= ovf_d;
        end
    end

    assign bus.out    = out_q;
    assign bus.tc     = tc_q;
    assign bus.ovf    = ovf_q;
    assign bus.at_max = (out_q == MAX_V);
    assign bus.at_min = (out_q == '0);
endmodule

// File: tb/tb_updown_counter_param.sv
// Directed bench for updown_counter_param (WIDTH=4, MAX_COUNT=9) in wrap and saturate variants.
module tb_updown_counter_param;
    logic clk = 1'b0;
    logic rst_w = 1'b0;
    logic rst_s = 1'b0;
    int   checks = 0;
    int   errors = 0;

    typedef struct {
        int sel;
        int o;
        int tc;
        int ovf;
    } exp_t;
    exp_t sb[$];

    always #5 clk = ~clk;

    updown_counter_param_if #(.WIDTH(4)) bw ();
    updown_counter_param_if #(.WIDTH(4)) bs ();

    updown_counter_param #(.WIDTH(4), .MAX_COUNT(9), .SATURATE(1'b0)) dut_w (
        .clk_i(clk), .reset_i(rst_w), .bus(bw)
    );
    updown_counter_param #(.WIDTH(4), .MAX_COUNT(9), .SATURATE(1'b1)) dut_s (
        .clk_i(clk), .reset_i(rst_s), .bus(bs)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Drive one cycle on the selected DUT, queue the expectation, then compare after the edge.
    task automatic cyc(input int sel, input logic r, input logic l, input logic [3:0] lv,
                       input logic e, input logic u, input int eo, input int etc, input int eovf);
        exp_t x;
        if (sel == 0) begin
            rst_w = r; bw.load = l; bw.load_val = lv; bw.en = e; bw.up = u;
        end else begin
            rst_s = r; bs.load = l; bs.load_val = lv; bs.en = e; bs.up = u;
        end
        x.sel = sel; x.o = eo; x.tc = etc; x.ovf = eovf;
        sb.push_back(x);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL scoreboard: observed empty queue expected entry");
        end else begin
            x = sb.pop_front();
            if (x.sel == 0) begin
                chk("wrap.out",    32'(bw.out),    32'(x.o));
                chk("wrap.tc",     32'(bw.tc),     32'(x.tc));
                chk("wrap.ovf",    32'(bw.ovf),    32'(x.ovf));
                chk("wrap.at_max", 32'(bw.at_max), 32'(x.o == 9));
                chk("wrap.at_min", 32'(bw.at_min), 32'(x.o == 0));
            end else begin
                chk("sat.out",    32'(bs.out),    32'(x.o));
                chk("sat.tc",     32'(bs.tc),     32'(x.tc));
                chk("sat.ovf",    32'(bs.ovf),    32'(x.ovf));
                chk("sat.at_max", 32'(bs.at_max), 32'(x.o == 9));
                chk("sat.at_min", 32'(bs.at_min), 32'(x.o == 0));
            end
        end
    endtask

    initial begin
        bw.en = 1'b0; bw.up = 1'b1; bw.load = 1'b0; bw.load_val = '0;
        bs.en = 1'b0; bs.up = 1'b1; bs.load = 1'b0; bs.load_val = '0;

        // Reset value follows direction
        cyc(0, 1, 0, 0, 0, 1, 0, 0, 0);
        cyc(0, 1, 0, 0, 0, 0, 9, 0, 0);
        cyc(0, 1, 0, 0, 0, 1, 0, 0, 0);

        // Count up 12 clocks from 0 with one wrap
        for (int i = 1; i <= 9; i++) cyc(0, 0, 0, 0, 1, 1, i, 0, 0);
        cyc(0, 0, 0, 0, 1, 1, 0, 1, 1);
        cyc(0, 0, 0, 0, 1, 1, 1, 0, 1);
        cyc(0, 0, 0, 0, 1, 1, 2, 0, 1);

        // Count down from 2 through the low boundary
        cyc(0, 0, 0, 0, 1, 0, 1, 0, 1);
        cyc(0, 0, 0, 0, 1, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 1, 0, 9, 1, 1);
        cyc(0, 0, 0, 0, 1, 0, 8, 0, 1);

        // en low holds count and ovf
        cyc(0, 0, 0, 0, 0, 0, 8, 0, 1);
        cyc(0, 0, 0, 0, 0, 1, 8, 0, 1);

        // Load clamps, overrides en, clears ovf
        cyc(0, 0, 1, 4'hF, 1, 1, 9, 0, 0);
        cyc(0, 0, 1, 4'd3, 0, 1, 3, 0, 0);
        cyc(0, 0, 1, 4'd9, 1, 0, 9, 0, 0);

        // Reset beats load; direction toggles per step
        cyc(0, 0, 1, 4'd5, 0, 1, 5, 0, 0);
        cyc(0, 1, 1, 4'd7, 1, 1, 0, 0, 0);
        cyc(0, 0, 0, 0, 1, 1, 1, 0, 0);
        cyc(0, 0, 0, 0, 1, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 1, 1, 1, 0, 0);

        // Saturating variant: hold at max with repeated tc
        cyc(1, 1, 0, 0, 0, 1, 0, 0, 0);
        cyc(1, 0, 1, 4'd8, 0, 1, 8, 0, 0);
        cyc(1, 0, 0, 0, 1, 1, 9, 0, 0);
        cyc(1, 0, 0, 0, 1, 1, 9, 1, 1);
        cyc(1, 0, 0, 0, 1, 1, 9, 1, 1);
        cyc(1, 0, 0, 0, 1, 1, 9, 1, 1);
        cyc(1, 0, 0, 0, 0, 1, 9, 0, 1);

        // Saturating variant: hold at zero counting down
        cyc(1, 0, 1, 4'd1, 1, 0, 1, 0, 0);
        cyc(1, 0, 0, 0, 1, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 1, 0, 0, 1, 1);
        cyc(1, 0, 0, 0, 1, 0, 0, 1, 1);
        cyc(1, 0, 0, 0, 1, 1, 1, 0, 1);

        // Reset mid-count clears sticky flag, down direction gives MAX
        cyc(1, 1, 0, 0, 1, 0, 9, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
